dma_xfer_ctrl: RTL
==================

Name: dma_xfer_ctrl

Overview:
Transfer sequencer for the DMA controller. It takes source address, destination address, length and transfer size from the DMA internal register block and moves the data through the shared DMA FIFO.
- Read phase: issues host-bus reads into the FIFO until the FIFO is full or all source data has been read.
- Write phase: drains the FIFO to the destination with host-bus writes.
- Alternates read and write phases until the length is exhausted.
- Reports busy/done/error and per-beat pulses back to the register block.

Parameters:
padd_size, 24, host address width
data_size, 32, data bus and length-counter width
cmd_size, 3, host command width
dma_fifo_depth, 4, FIFO address width (capacity 2**dma_fifo_depth words)

Ports:
clk0  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  start/continue request; level-sensitive
size  in  3  one-hot: [0] byte, [1] halfword, [2] word
src_addr  in  padd_size  read master start address
dst_addr  in  padd_size  write master start address
len_bytes  in  data_size  transfer length in bytes
mem_cmd  out  cmd_size  000 idle, 001 read, 010 write
mem_addr  out  padd_size  bus address
mem_ack  in  1  bus beat complete; sampled while mem_cmd != 000
mem_datain  in  data_size  read data, valid with mem_ack
mem_dataout  out  data_size  write data (= fifo_rdata)
fifo_full  in  1  FIFO full
fifo_empty  in  1  FIFO empty
fifo_rdata  in  data_size  FIFO head word (show-ahead)
fifo_wr  out  1  push mem_datain into FIFO
fifo_rd  out  1  pop FIFO head
busy  out  1  transfer in progress
done  out  1  transfer completed
err  out  1  illegal size code at start
bytes_left  out  data_size  destination bytes not yet written

Behaviour:
- Reset: all outputs 0; mem_cmd=000; state IDLE.
- Reset asserted mid-transfer aborts the transfer: no further bus beat is issued.
- step = 1/2/4 from size.
- States: IDLE, LOAD, RD, WR, FIN, ERR.
- IDLE -> LOAD when go=1.
- LOAD (1 cycle):
  - Captures rd_ptr=src_addr, wr_ptr=dst_addr, rd_left=wr_left=len_bytes.
  - busy=1.
  - If size is not one-hot: -> ERR.
  - Else if len_bytes < step: -> FIN.
  - Else: -> RD.
- RD:
  - mem_cmd=001, mem_addr=rd_ptr, held stable until mem_ack.
  - On mem_ack: fifo_wr=1 in the same cycle (combinational on mem_ack); rd_ptr+=step; rd_left-=step.
  - After the ack beat: if rd_left < step or fifo_full (including the word just pushed), -> WR.
- WR:
  - Requires fifo_empty=0; otherwise mem_cmd=000 and wait.
  - mem_cmd=010, mem_addr=wr_ptr, mem_dataout=fifo_rdata.
  - On mem_ack: fifo_rd=1 in the same cycle; wr_ptr+=step; wr_left-=step.
  - After the beat: if wr_left < step -> FIN; else if the FIFO is now empty and rd_left >= step -> RD.
- FIN: busy=0, done=1, held while go=1. go=0 -> IDLE, done cleared.
- ERR: busy=0, err=1, held while go=1. go=0 -> IDLE, err cleared.
- Abort: go=0 in RD/WR.
  - If a beat is outstanding (mem_cmd != 000), it completes: wait for mem_ack, with the normal fifo side effect.
  - Then -> IDLE with done=0, busy=0.
  - The FIFO is not flushed by this block.
- Residual bytes: when len_bytes is not a multiple of step, the final (len_bytes mod step) bytes are not transferred; the transfer is complete once remaining < step.
- Address arithmetic is modulo 2**padd_size (wraps 0xFFFFFF -> 0x000000 for byte step).
- Counters never go below 0.
- bytes_left = wr_left while busy; 0 in IDLE.
- Only one of fifo_wr/fifo_rd is asserted per cycle: reads and writes never overlap.
- mem_ack while mem_cmd=000 is ignored.
- go, size, addresses and length are sampled only in LOAD; changes after LOAD have no effect, except go=0 (abort/return to IDLE).

Decomposition:
- Shared parameter.v holds:
  - command codes CMD_IDLE=3'b000, CMD_RD=3'b001, CMD_WR=3'b010;
  - size codes SZ_BYTE=3'b001, SZ_HW=3'b010, SZ_WORD=3'b100;
  - state encodings.
- One sub-module, dma_addr_cnt: pointer plus remaining counter with load, step and wrap. Instantiated twice (read side, write side).

Test Plan:
- Word, 16 bytes, src=0x000100, dst=0x000200, FIFO depth 16, ack each cycle after cmd -> 4 reads at 0x100..0x10C, then 4 writes at 0x200..0x20C; data order preserved; done=1; bytes_left=0.
- Word, 80 bytes (20 words), FIFO depth 16 -> reads 16, writes 16, reads 4, writes 4; fifo_full triggers the first phase switch; no FIFO overflow or underflow.
- Byte, len=3, src=0xFFFFFE -> reads at 0xFFFFFE, 0xFFFFFF, 0x000000 (wrap); done=1.
- Halfword, len=5 -> exactly 2 read and 2 write beats; the final byte is dropped; done=1. Separately, len=0 or len=1 with step=2 -> LOAD -> FIN with no bus command.
- size=3'b011 with go=1 -> err=1, busy=0, no bus traffic; go=0 -> err=0, state IDLE.
- go dropped during an RD beat with ack delayed 3 cycles -> mem_cmd held until ack, fifo_wr pulses once, then IDLE with done=0. Separately, reset asserted mid-WR -> next cycle all outputs 0.

Source files
------------

// File: rtl/dma_xfer_ctrl_pkg.sv
// Shared codes for the DMA transfer sequencer: bus commands, size encodings, FSM states.
package dma_xfer_ctrl_pkg;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b001;
  localparam logic [2:0] CMD_WR   = 3'b010;

  localparam logic [2:0] SZ_BYTE  = 3'b001;
  localparam logic [2:0] SZ_HW    = 3'b010;
  localparam logic [2:0] SZ_WORD  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD, S_WR, S_FIN, S_ERR
  } state_t;

  // Byte step for a size code; 0 flags a code that is not one-hot.
  function automatic logic [2:0] step_of(input logic [2:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HW:   return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dma_addr_cnt.sv
// Address pointer plus remaining-byte counter; pointer wraps, counter saturates at 0.
module dma_addr_cnt #(
  parameter int AW = 24,
  parameter int DW = 32
) (
  input  logic          clk0,
  input  logic          reset,
  input  logic          load,
  input  logic          stp,
  input  logic [AW-1:0] ld_ptr,
  input  logic [DW-1:0] ld_len,
  input  logic [2:0]    step,
  output logic [AW-1:0] ptr,
  output logic [DW-1:0] left
);

  logic [DW-1:0] step_w;
  assign step_w = DW'(step);

  always_ff @(posedge clk0) begin
    if (reset) begin
      ptr  <= '0;
      left <= '0;
    end else if (load) begin
      ptr  <= ld_ptr;
      left <= ld_len;
    end else if (stp) begin
      ptr  <= ptr + AW'(step);
      left <= (left >= step_w) ? left - step_w : '0;
    end
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// DMA transfer sequencer: alternates host-bus read bursts into the FIFO with write bursts out of it.
module dma_xfer_ctrl
  import dma_xfer_ctrl_pkg::*;
#(
  parameter int padd_size      = 24,
  parameter int data_size      = 32,
  parameter int cmd_size       = 3,
  parameter int dma_fifo_depth = 4
) (
  input  logic                 clk0,
  input  logic                 reset,
  input  logic                 go,
  input  logic [2:0]           size,
  input  logic [padd_size-1:0] src_addr,
  input  logic [padd_size-1:0] dst_addr,
  input  logic [data_size-1:0] len_bytes,
  output logic [cmd_size-1:0]  mem_cmd,
  output logic [padd_size-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [data_size-1:0] mem_datain,
  output logic [data_size-1:0] mem_dataout,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [data_size-1:0] fifo_rdata,
  output logic                 fifo_wr,
  output logic                 fifo_rd,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [data_size-1:0] bytes_left
);

  localparam int FIFO_WORDS = 2 ** dma_fifo_depth;

  state_t                  state;
  logic [2:0]              step_r;
  logic [data_size-1:0]    step_w, ld_step;
  logic [padd_size-1:0]    rd_ptr, wr_ptr;
  logic [data_size-1:0]    rd_left, wr_left;
  logic [dma_fifo_depth:0] rd_burst;
  logic                    ld, cmd_rd, cmd_wr;

  assign ld      = (state == S_LOAD);
  assign step_w  = data_size'(step_r);
  assign ld_step = data_size'(step_of(size));
  assign cmd_rd  = (mem_cmd == cmd_size'(CMD_RD));
  assign cmd_wr  = (mem_cmd == cmd_size'(CMD_WR));

  // FIFO strobes follow the ack combinationally; only one bus command exists at a time.
  assign fifo_wr     = cmd_rd & mem_ack;
  assign fifo_rd     = cmd_wr & mem_ack;
  assign mem_addr    = cmd_rd ? rd_ptr : (cmd_wr ? wr_ptr : '0);
  assign mem_dataout = cmd_wr ? fifo_rdata : '0;
  assign bytes_left  = busy ? wr_left : '0;

  dma_addr_cnt #(.AW(padd_size), .DW(data_size)) u_rd_cnt (
    .clk0(clk0), .reset(reset), .load(ld), .stp(fifo_wr),
    .ld_ptr(src_addr), .ld_len(len_bytes), .step(step_r),
    .ptr(rd_ptr), .left(rd_left)
  );

  dma_addr_cnt #(.AW(padd_size), .DW(data_size)) u_wr_cnt (
    .clk0(clk0), .reset(reset), .load(ld), .stp(fifo_rd),
    .ld_ptr(dst_addr), .ld_len(len_bytes), .step(step_r),
    .ptr(wr_ptr), .left(wr_left)
  );

  // Each beat is followed by one idle-bus cycle so that fifo_full/fifo_empty
  // already reflect the word just pushed or popped when the next step is chosen.
  always_ff @(posedge clk0) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_cmd  <= '0;
      step_r   <= '0;
      rd_burst <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          state <= S_LOAD;
          busy  <= 1'b1;
        end
        S_LOAD: begin
          step_r   <= step_of(size);
          rd_burst <= '0;
          if (ld_step == '0) begin
            state <= S_ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (len_bytes < ld_step) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_RD;
          end
        end
        S_RD: begin
          if (cmd_rd) begin
            if (mem_ack) begin
              mem_cmd  <= cmd_size'(CMD_IDLE);
              rd_burst <= rd_burst + 1'b1;
            end
          end else if (!go) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (rd_left < step_w || fifo_full ||
                       rd_burst == FIFO_WORDS[dma_fifo_depth:0]) begin
            state <= S_WR;
          end else begin
            mem_cmd <= cmd_size'(CMD_RD);
          end
        end
        S_WR: begin
          if (cmd_wr) begin
            if (mem_ack) mem_cmd <= cmd_size'(CMD_IDLE);
          end else if (!go) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (wr_left < step_w) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (fifo_empty) begin
            if (rd_left >= step_w) begin
              state    <= S_RD;
              rd_burst <= '0;
            end
          end else begin
            mem_cmd <= cmd_size'(CMD_WR);
          end
        end
        S_FIN: if (!go) begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        S_ERR: if (!go) begin
          state <= S_IDLE;
          err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
